// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the pipelined adder:
//     - DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//     - chunk_width()          : bits handled by each pipeline stage
//     - stage_rec_t            : per-stage pipeline record for the default
//                                configuration {valid, carry, sum_lo, a_hi, b_hi}
//   Optional feature macro used by the design: ADDER_OVF_EN (signed overflow).
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Number of carry-chain bits resolved by each stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Record held by every stage register. sum_lo holds the chunks already
  // added (upper bits still zero); a_hi/b_hi carry the operands forward so
  // later stages can add their own chunk.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum_lo;
    logic [DEF_WIDTH-1:0] a_hi;
    logic [DEF_WIDTH-1:0] b_hi;
  } stage_rec_t;

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
//   One pipeline stage of the pipelined adder. Adds chunk K of the delayed
//   operands with the carry handed over by the previous stage, merges the
//   result into the running sum and registers the whole stage record.
//   All stages share one advance enable, so the pipeline shifts or holds as
//   a single unit.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   i_adv               shift enable shared by all stages
//   i_valid, i_carry    valid bit and carry from the previous stage (or input)
//   i_sum               running sum with chunks 0..K-1 already filled in
//   i_a, i_b            delayed operands
//   o_valid, o_carry    registered valid bit and carry out of chunk K
//   o_sum               registered running sum with chunks 0..K filled in
//   o_a, o_b            registered operands for the next stage
// -----------------------------------------------------------------------------
module adder_chunk
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int K      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_adv,
  input  logic             i_valid,
  input  logic             i_carry,
  input  logic [WIDTH-1:0] i_sum,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic             o_carry,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LSB   = K * CHUNK;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum_lo;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
  } rec_t;

  rec_t             r_rec;
  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_sum_next;

  // CHUNK-bit add; the extra top bit is the carry into the next chunk.
  always_comb begin
    w_chunk    = {1'b0, i_a[LSB +: CHUNK]} + {1'b0, i_b[LSB +: CHUNK]}
               + {{CHUNK{1'b0}}, i_carry};
    w_sum_next = i_sum;
    w_sum_next[LSB +: CHUNK] = w_chunk[CHUNK-1:0];
  end

  // Bubbles shift through like data; only the valid bit distinguishes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rec <= '0;
    end else if (i_adv) begin
      r_rec <= '{valid:  i_valid,
                 carry:  w_chunk[CHUNK],
                 sum_lo: w_sum_next,
                 a_hi:   i_a,
                 b_hi:   i_b};
    end
  end

  assign o_valid = r_rec.valid;
  assign o_carry = r_rec.carry;
  assign o_sum   = r_rec.sum_lo;
  assign o_a     = r_rec.a_hi;
  assign o_b     = r_rec.b_hi;

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit adder with carry-in whose carry chain is split into STAGES equal
//   chunks, one register stage per chunk. One operand pair per cycle, result
//   STAGES edges after acceptance, full backpressure.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The whole pipeline advances when the output register is
// empty or being drained (adv = !out_valid || out_ready); in_ready equals adv.
// While out_valid && !out_ready every stage, including the outputs, holds.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_valid      a/b/cin valid this cycle
//   in_ready      block can accept this cycle
//   a, b, cin     operands and carry-in into bit 0
//   out_valid     sum/cout valid
//   out_ready     downstream accepts this cycle
//   sum           (a + b + cin) mod 2^WIDTH
//   cout          carry out of bit WIDTH-1
//   ovf           signed overflow, present only when ADDER_OVF_EN is defined
//
// Configuration macro: ADDER_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVF_EN
 ,output logic             ovf
`endif
);

  if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be in 1..WIDTH");
  end
  if ((WIDTH % STAGES) != 0) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  // Index 0 is the input side; index k+1 is the output of stage k.
  logic             w_valid [STAGES+1];
  logic             w_carry [STAGES+1];
  logic [WIDTH-1:0] w_sum   [STAGES+1];
  logic [WIDTH-1:0] w_a     [STAGES+1];
  logic [WIDTH-1:0] w_b     [STAGES+1];
  logic             w_adv;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage 0 only captures a real transfer because in_ready == adv.
  assign w_valid[0] = in_valid;
  assign w_carry[0] = cin;
  assign w_sum[0]   = '0;
  assign w_a[0]     = a;
  assign w_b[0]     = b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .K      (k)
    ) u_chunk (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_adv   (w_adv),
      .i_valid (w_valid[k]),
      .i_carry (w_carry[k]),
      .i_sum   (w_sum[k]),
      .i_a     (w_a[k]),
      .i_b     (w_b[k]),
      .o_valid (w_valid[k+1]),
      .o_carry (w_carry[k+1]),
      .o_sum   (w_sum[k+1]),
      .o_a     (w_a[k+1]),
      .o_b     (w_b[k+1])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign sum       = w_sum[STAGES];
  assign cout      = w_carry[STAGES];

`ifdef ADDER_OVF_EN
  // Uses the operand MSBs registered alongside the final sum, so ovf is
  // aligned with sum, holds with it on a stall and resets to 0.
  assign ovf = (w_a[STAGES][WIDTH-1] == w_b[STAGES][WIDTH-1]) &&
               (w_sum[STAGES][WIDTH-1] != w_a[STAGES][WIDTH-1]);
`endif

  // The last stage's operand copies are only needed for ovf (MSBs).
  logic w_unused;
  assign w_unused = ^{w_a[STAGES], w_b[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int W = 32;
  localparam int S = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (W=32, S=4) ----------------
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
  // ---------------- W=8, S=1 ----------------
  logic         v8, ir8, c8, ov8, rdy8, cout8;
  logic [7:0]   a8, b8, s8;
  // ---------------- W=64, S=8 ----------------
  logic         v64, ir64, c64, ov64, rdy64, cout64;
  logic [63:0]  a64, b64, s64;
`ifdef ADDER_OVF_EN
  logic ovf, ovf8, ovf64;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef ADDER_OVF_EN
   ,.ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(ir8),
    .a(a8), .b(b8), .cin(c8), .out_valid(ov8), .out_ready(rdy8),
    .sum(s8), .cout(cout8)
`ifdef ADDER_OVF_EN
   ,.ovf(ovf8)
`endif
  );

  pipelined_adder #(.WIDTH(64), .STAGES(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ir64),
    .a(a64), .b(b64), .cin(c64), .out_valid(ov64), .out_ready(rdy64),
    .sum(s64), .cout(cout64)
`ifdef ADDER_OVF_EN
   ,.ovf(ovf64)
`endif
  );

  // ---------------- bookkeeping ----------------
  int          total = 0;
  int          bad   = 0;
  int          pops = 0, first_pop = 0, last_pop = 0;
  logic [33:0] exp_q[$];   // {ovf, cout, sum}

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic for the unsigned result and a signed
  // range check for overflow.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic c);
    longint unsigned u;
    longint          s;
    logic            v;
    u = 64'(x) + 64'(y) + 64'(c);
    s = longint'($signed(x)) + longint'($signed(y)) + longint'({1'b0, c});
    v = (s >= (64'sd1 <<< 31)) || (s < -(64'sd1 <<< 31));
    return {v, u[32:0]};
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- scoreboard (samples on the falling edge) ----------------
  logic [33:0] front;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready_rule", in_ready, (!out_valid || out_ready));
      if (out_valid) begin
        chk("out_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          front = exp_q[0];
          chk("sb_sum_cout", {cout, sum}, front[32:0]);
`ifdef ADDER_OVF_EN
          chk("sb_ovf", ovf, front[33]);
`endif
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
    end
  end

  // ---------------- driver tasks ----------------
  // Entered at posedge+1 with an empty pipeline; returns at the falling edge
  // where out_valid is seen, n = edges from acceptance to result (inclusive).
  task automatic send_wait(input logic [31:0] ta, input logic [31:0] tb,
                           input logic tc, output int n);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1 in_valid = 1'b0;
      @(negedge clk);
    end while (!out_valid && n < 40);
  endtask

  task automatic drive_rand(input logic v);
    in_valid = v; a = rnd32(); b = rnd32(); cin = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int k;
    k = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n, stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0; rdy8 = 1;
    v64 = 0; a64 = 0; b64 = 0; c64 = 0; rdy64 = 1;

    // Reset state
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
`ifdef ADDER_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    chk("rst_out_valid8", ov8, 1'b0);
    chk("rst_sum64", s64, 64'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1'b1);
    chk("in_ready8_after_rst", ir8, 1'b1);
    chk("in_ready64_after_rst", ir64, 1'b1);
    @(posedge clk); #1;

    // 1: carry across every chunk, latency = STAGES edges
    send_wait(32'hFFFF_FFFF, 32'h1, 1'b0, n);
    chk("t1_latency", n, S);
    chk("t1_sum", sum, 32'h0);
    chk("t1_cout", cout, 1'b1);
    @(posedge clk); #1;
    drain();

    // 2: 16 back-to-back random pairs, no gaps in the output
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      drive_rand(1'b1);
      @(negedge clk);
      chk("t2_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
    end
    drain();
    chk("t2_count", pops, 16);
    chk("t2_no_gaps", last_pop - first_pop, 15);

    // 3: fill the pipeline with out_ready low, stall 5 cycles, then release
    pops = 0;
    out_ready = 1'b0;
    for (int i = 0; i < S; i++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      @(negedge clk);
      chk("t3_in_ready_low", in_ready, 1'b0);
      chk("t3_out_valid", out_valid, 1'b1);
      front = exp_q[0];
      chk("t3_held", {cout, sum}, front[32:0]);
      @(posedge clk); #1;
    end
    drain();
    chk("t3_count", pops, S);

    // 4: reset mid-stream, nothing stale afterwards
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("t4_out_valid", out_valid, 1'b0);
    chk("t4_sum", sum, 32'h0);
    chk("t4_cout", cout, 1'b0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    chk("t4_no_stale", stale, 0);

`ifdef ADDER_OVF_EN
    // 5: signed overflow cases
    send_wait(32'h7FFF_FFFF, 32'h1, 1'b0, n);
    chk("t5a_sum", sum, 32'h8000_0000);
    chk("t5a_ovf", ovf, 1'b1);
    chk("t5a_cout", cout, 1'b0);
    @(posedge clk); #1;
    send_wait(32'h8000_0000, 32'h8000_0000, 1'b0, n);
    chk("t5b_sum", sum, 32'h0);
    chk("t5b_ovf", ovf, 1'b1);
    chk("t5b_cout", cout, 1'b1);
    @(posedge clk); #1;
    drain();
`endif

    // Random traffic with bubbles and backpressure
    for (int i = 0; i < 300; i++) begin
      drive_rand(1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    drain();

    // 6: W=8,S=1 and W=64,S=8 with all-ones operands and cin=1
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1 v8 = 1'b0;
      @(negedge clk);
    end while (!ov8 && n < 40);
    chk("t6_lat8", n, 1);
    chk("t6_sum8", s8, 8'hFF);
    chk("t6_cout8", cout8, 1'b1);
`ifdef ADDER_OVF_EN
    chk("t6_ovf8", ovf8, 1'b0);
`endif
    @(posedge clk); #1;

    a64 = '1; b64 = '1; c64 = 1'b1; v64 = 1'b1;
    n = 0;
    do begin
      @(posedge clk); n++; #1 v64 = 1'b0;
      @(negedge clk);
    end while (!ov64 && n < 40);
    chk("t6_lat64", n, 8);
    chk("t6_sum64", s64, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t6_cout64", cout64, 1'b1);
`ifdef ADDER_OVF_EN
    chk("t6_ovf64", ovf64, 1'b0);
`endif
    @(posedge clk); #1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
